// File: rtl/s64_cmd_regfile.sv
// Register-command executor behind the 64-bit SPI frame assembler: decodes one command per
// received frame, updates a small register file and hands a 64-bit response back for the next frame.
module s64_cmd_regfile #(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'h5350_4936
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] rx_word,
  input  logic        rx_busy,
  output logic [63:0] tx_word,
  input  logic [31:0] status_in,
  output logic [31:0] ctrl_out,
  output logic        cmd_done,
  output logic [7:0]  overrun_cnt
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;

  state_t      state;
  logic        rx_busy_q;
  logic [63:0] cmd_q;
  logic [63:0] skid_q;
  logic        skid_vld;
  logic        skid_src;
  logic [7:0]  code_q;
  logic [31:0] pre_q;
  logic [15:0] seq;
  logic [63:0] resp_q;
  logic        resp_pending;
  logic [31:0] regs [0:NUM_REGS-1];

  logic          trig;
  logic [7:0]    opcode;
  logic [7:0]    addr;
  logic [31:0]   data;
  logic [AW-1:0] idx;
  logic [7:0]    dec_code;
  logic [31:0]   rd_val;
  logic          skid_drop;
  logic          resp_lost;
  logic [8:0]    ovr_sum;
  logic          unused;

  assign trig     = rx_busy_q & ~rx_busy;
  assign opcode   = cmd_q[63:56];
  assign addr     = cmd_q[55:48];
  assign data     = cmd_q[31:0];
  assign idx      = addr[AW-1:0];
  assign unused   = ^cmd_q[47:32];
  assign ctrl_out = regs[1];

  always_comb begin
    dec_code = 8'h00;
    if (opcode > 8'h04)
      dec_code = 8'h01;
    else if (opcode != 8'h00 && {1'b0, addr} >= 9'(NUM_REGS))
      dec_code = 8'h02;
    else if ((opcode == 8'h01 || opcode == 8'h03 || opcode == 8'h04) &&
             (addr == 8'd0 || addr == 8'd2))
      dec_code = 8'h03;
  end

  // Out-of-range indices only reach this mux when the status code already blocks the access.
  always_comb begin
    rd_val = regs[idx];
    if (addr == 8'd0)
      rd_val = ID_VALUE;
    else if (addr == 8'd2)
      rd_val = status_in;
  end

  // A response is lost only if the previous one could not drain in this same cycle.
  assign skid_drop = trig && (state != IDLE) && skid_vld;
  assign resp_lost = (state == RESP) && resp_pending && rx_busy;
  assign ovr_sum   = {1'b0, overrun_cnt} + {8'd0, skid_drop} + {8'd0, resp_lost};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rx_busy_q    <= 1'b0;
      cmd_q        <= '0;
      skid_q       <= '0;
      skid_vld     <= 1'b0;
      skid_src     <= 1'b0;
      code_q       <= '0;
      pre_q        <= '0;
      seq          <= '0;
      resp_q       <= '0;
      resp_pending <= 1'b0;
      tx_word      <= '0;
      cmd_done     <= 1'b0;
      overrun_cnt  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      rx_busy_q   <= rx_busy;
      cmd_done    <= 1'b0;
      overrun_cnt <= ovr_sum[8] ? 8'hFF : ovr_sum[7:0];

      if (resp_pending && !rx_busy) begin
        tx_word      <= resp_q;
        resp_pending <= 1'b0;
      end

      if (trig && state != IDLE && !skid_vld) begin
        skid_q   <= rx_word;
        skid_vld <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (trig) begin
            cmd_q <= rx_word;
            state <= DECODE;
          end
        end
        DECODE: begin
          code_q   <= dec_code;
          cmd_done <= 1'b1;
          state    <= EXEC;
          // The skid slot stays occupied until the command taken from it has been decoded.
          if (skid_src) begin
            skid_vld <= 1'b0;
            skid_src <= 1'b0;
          end
        end
        EXEC: begin
          pre_q <= '0;
          if (code_q == 8'h00 && opcode != 8'h00) begin
            pre_q <= rd_val;
            case (opcode)
              8'h01:   regs[idx] <= data;
              8'h03:   regs[idx] <= regs[idx] | data;
              8'h04:   regs[idx] <= regs[idx] & ~data;
              default: ;
            endcase
          end
          seq   <= seq + 16'd1;
          state <= RESP;
        end
        RESP: begin
          resp_q       <= {code_q, addr, seq - 16'd1, pre_q};
          resp_pending <= 1'b1;
          if (skid_vld) begin
            cmd_q    <= skid_q;
            skid_src <= 1'b1;
            state    <= DECODE;
          end else if (trig) begin
            cmd_q    <= rx_word;
            skid_src <= 1'b1;
            state    <= DECODE;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s64_cmd_regfile.sv
// Bench for s64_cmd_regfile: directed frames, a schedule-based command model checked every cycle,
// plus literal response words worked out by hand.
module tb_s64_cmd_regfile;

  localparam int          NUM_REGS = 16;
  localparam logic [31:0] ID_VALUE = 32'h5350_4936;

  logic        clk;
  logic        reset;
  logic [63:0] rx_word;
  logic        rx_busy;
  logic [63:0] tx_word;
  logic [31:0] status_in;
  logic [31:0] ctrl_out;
  logic        cmd_done;
  logic [7:0]  overrun_cnt;

  int n_cmp;
  int n_bad;

  s64_cmd_regfile #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_word     (rx_word),
    .rx_busy     (rx_busy),
    .tx_word     (tx_word),
    .status_in   (status_in),
    .ctrl_out    (ctrl_out),
    .cmd_done    (cmd_done),
    .overrun_cnt (overrun_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: each accepted command gets an absolute decode cycle; it executes one cycle later and
  // produces its response the cycle after that. One queued word may wait behind it.
  logic [31:0] m_regs [0:255];
  logic [15:0] m_seq;
  int          m_lost;
  logic [63:0] m_tx;
  logic [63:0] m_resp;
  logic [63:0] ex_res;
  bit          m_pending;
  bit          m_busy_q;
  bit          cur_vld;
  bit          q_vld;
  bit          q_hold;
  logic [63:0] cur_word;
  logic [63:0] q_word;
  int          cur_start;
  int          cyc;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_regs[i] = '0;
    m_seq = '0; m_lost = 0; m_tx = '0; m_resp = '0; ex_res = '0;
    m_pending = 0; m_busy_q = 0; cur_vld = 0; q_vld = 0; q_hold = 0;
    cur_word = '0; q_word = '0; cur_start = -10;
  endtask

  task automatic execute(input logic [63:0] w);
    logic [7:0]  op;
    logic [7:0]  a;
    logic [7:0]  code;
    logic [31:0] d;
    logic [31:0] pre;
    op = w[63:56]; a = w[55:48]; d = w[31:0]; pre = '0;
    if (op > 8'h04) code = 8'h01;
    else if (op != 8'h00 && int'(a) >= NUM_REGS) code = 8'h02;
    else if ((op == 8'h01 || op == 8'h03 || op == 8'h04) && (a == 8'd0 || a == 8'd2)) code = 8'h03;
    else code = 8'h00;
    if (code == 8'h00 && op != 8'h00) begin
      if (a == 8'd0) pre = ID_VALUE;
      else if (a == 8'd2) pre = status_in;
      else pre = m_regs[a];
      if (op == 8'h01) m_regs[a] = d;
      else if (op == 8'h03) m_regs[a] = pre | d;
      else if (op == 8'h04) m_regs[a] = pre & ~d;
    end
    ex_res = {code, a, m_seq, pre};
    m_seq  = m_seq + 16'd1;
  endtask

  task automatic model_step();
    bit trig;
    int c;
    c = cyc;
    cyc++;
    if (reset) begin
      model_reset();
      return;
    end
    trig = m_busy_q && !rx_busy;
    m_busy_q = rx_busy;
    if (m_pending && !rx_busy) begin
      m_tx = m_resp;
      m_pending = 0;
    end
    if (cur_vld && c == cur_start + 1) execute(cur_word);
    if (trig) begin
      if (!cur_vld) begin
        cur_vld = 1; cur_word = rx_word; cur_start = c + 1;
      end else if (q_vld) begin
        m_lost++;
      end else begin
        q_vld = 1; q_word = rx_word;
      end
    end
    if (q_hold && c == cur_start) begin
      q_vld = 0; q_hold = 0;
    end
    if (cur_vld && c == cur_start + 2) begin
      if (m_pending) m_lost++;
      m_resp = ex_res;
      m_pending = 1;
      if (q_vld) begin
        cur_word = q_word; cur_start = c + 1; q_hold = 1;
      end else begin
        cur_vld = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      n_cmp++;
      if (tx_word !== m_tx) begin
        n_bad++;
        $display("FAIL tx_word cyc=%0d got %h want %h", cyc, tx_word, m_tx);
      end
      n_cmp++;
      if (ctrl_out !== m_regs[1]) begin
        n_bad++;
        $display("FAIL ctrl_out cyc=%0d got %h want %h", cyc, ctrl_out, m_regs[1]);
      end
      n_cmp++;
      if (cmd_done !== (cur_vld && cyc == cur_start + 1)) begin
        n_bad++;
        $display("FAIL cmd_done cyc=%0d got %b want %b", cyc, cmd_done, cur_vld && cyc == cur_start + 1);
      end
      n_cmp++;
      if (overrun_cnt !== ((m_lost > 255) ? 8'hFF : 8'(m_lost))) begin
        n_bad++;
        $display("FAIL overrun_cnt cyc=%0d got %0d want %0d", cyc, overrun_cnt, m_lost);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic frame(input logic [63:0] w);
    rx_busy = 1'b1;
    tick();
    rx_busy = 1'b0;
    rx_word = w;
    tick();
  endtask

  task automatic send(input logic [63:0] w, input string name, input logic [63:0] want);
    frame(w);
    repeat (6) tick();
    @(negedge clk);
    check(name, tx_word, want);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    reset = 1'b1; rx_busy = 1'b0; rx_word = '0; status_in = 32'h1234_5678;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("reset_tx", tx_word, 64'h0);
    check("reset_ctrl", {32'h0, ctrl_out}, 64'h0);
    check("reset_ovr", {56'h0, overrun_cnt}, 64'h0);

    // NOP: done pulse two cycles after the trigger cycle
    frame(64'h0);
    tick();
    @(negedge clk);
    check("nop_done_e2", {63'h0, cmd_done}, 64'h1);
    repeat (4) tick();
    @(negedge clk);
    check("nop_resp", tx_word, 64'h0);

    do_reset();
    frame(64'h0101_0000_DEAD_BEEF);
    repeat (6) tick();
    @(negedge clk);
    check("ctrl_write", {32'h0, ctrl_out}, 64'hDEAD_BEEF);
    send(64'h0201_0000_0000_0000, "read_ctrl",   64'h0001_0001_DEAD_BEEF);
    send(64'h0305_0000_0000_000F, "set5",        64'h0005_0002_0000_0000);
    send(64'h0405_0000_0000_0003, "clr5",        64'h0005_0003_0000_000F);
    send(64'h0205_0000_0000_0000, "read5",       64'h0005_0004_0000_000C);
    send(64'h0200_0000_0000_0000, "read_id",     64'h0000_0005_5350_4936);
    send(64'h0202_0000_0000_0000, "read_status", 64'h0002_0006_1234_5678);
    send(64'h7F00_0000_0000_0000, "bad_opcode",  64'h0100_0007_0000_0000);
    send(64'h0220_0000_0000_0000, "bad_addr",    64'h0220_0008_0000_0000);
    send(64'h0100_0000_1111_1111, "write_ro",    64'h0300_0009_0000_0000);
    send(64'h0200_0000_0000_0000, "id_intact",   64'h0000_000A_5350_4936);
    send(64'h0030_0000_0000_0000, "nop_hi_addr", 64'h0030_000B_0000_0000);
    send(64'h020F_0000_0000_0000, "read_last",   64'h000F_000C_0000_0000);
    send(64'h0110_0000_0000_0001, "write_16",    64'h0210_000D_0000_0000);

    // Three frames two cycles apart: the third finds the skid still held
    rx_busy = 1'b1;
    tick();
    rx_busy = 1'b0; rx_word = 64'h0106_0000_0000_0066; tick();
    rx_busy = 1'b1; tick();
    rx_busy = 1'b0; rx_word = 64'h0107_0000_0000_0077; tick();
    rx_busy = 1'b1; tick();
    rx_busy = 1'b0; rx_word = 64'h0108_0000_0000_0088; tick();
    repeat (10) tick();
    @(negedge clk);
    check("skid_overrun", {56'h0, overrun_cnt}, 64'h1);
    send(64'h0208_0000_0000_0000, "dropped_cmd", 64'h0008_0010_0000_0000);
    send(64'h0207_0000_0000_0000, "skid_cmd",    64'h0007_0011_0000_0077);

    // Two responses while rx_busy stays high: only the second reaches tx_word
    rx_busy = 1'b1; tick();
    rx_busy = 1'b0; rx_word = 64'h0109_0000_0000_0099; tick();
    rx_busy = 1'b1; tick();
    rx_busy = 1'b0; rx_word = 64'h0209_0000_0000_0000; tick();
    rx_busy = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check("hold_tx", tx_word, 64'h0007_0011_0000_0077);
    check("resp_overrun", {56'h0, overrun_cnt}, 64'h2);
    rx_busy = 1'b0; rx_word = 64'h0;
    tick();
    @(negedge clk);
    check("second_resp", tx_word, 64'h0009_0013_0000_0099);
    repeat (6) tick();

    // Reset lands in the EXEC cycle of a write to register 3
    frame(64'h0103_0000_0000_CAFE);
    tick();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_tx", tx_word, 64'h0);
    check("rst_ovr", {56'h0, overrun_cnt}, 64'h0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    send(64'h0203_0000_0000_0000, "rst_no_write", 64'h0003_0000_0000_0000);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
